// File: rtl/pedal_pkg.sv
// Shared types for the pedal control plane: FSM state codes,
// green-LED encodings and key indices.
package pedal_pkg;

    typedef enum logic [2:0] {
        S_I2C   = 3'd0,
        S_PLAY  = 3'd1,
        S_SET   = 3'd2,
        S_RECD  = 3'd3,
        S_PLAYL = 3'd4
    } state_t;

    localparam logic [8:0] LEDG_I2C   = 9'h100;
    localparam logic [8:0] LEDG_PLAY  = 9'h001;
    localparam logic [8:0] LEDG_SET   = 9'h002;
    localparam logic [8:0] LEDG_RECD  = 9'h004;
    localparam logic [8:0] LEDG_PLAYL = 9'h008;

    localparam int KEY_VAL  = 0;
    localparam int KEY_LOOP = 1;
    localparam int KEY_MODE = 2;
    localparam int NUM_KEYS = 3;

    function automatic logic [8:0] ledg_of(input state_t s);
        logic [8:0] r;
        case (s)
            S_PLAY:  r = LEDG_PLAY;
            S_SET:   r = LEDG_SET;
            S_RECD:  r = LEDG_RECD;
            S_PLAYL: r = LEDG_PLAYL;
            default: r = LEDG_I2C;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pedal_ctrl_key_debounce.sv
// Key synchroniser plus stable-cycle debouncer; emits a one-cycle
// pulse on each debounced press, nothing on release.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            o_press <= 1'b0;
        end else begin
            s1      <= i_key;
            s2      <= s1;
            o_press <= 1'b0;
            // any sample matching the held level restarts the count
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt     <= '0;
                level   <= s2;
                o_press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pedal_ctrl.sv
// Pedal control plane: keys, mode FSM, parameter bank, indicators.
// Loop record/playback is built only when PEDAL_CTRL_LOOP_EN is defined.
module pedal_ctrl
    import pedal_pkg::*;
#(
    parameter int                        NUM_FX       = 8,
    parameter int                        PARAM_W      = 3,
    parameter int                        SEL_W        = $clog2(NUM_FX),
    parameter logic [NUM_FX*PARAM_W-1:0] DEFAULTS     = '0,
    parameter int                        DEBOUNCE_CYC = 16,
    parameter int                        LOOP_AW      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_i2c_done,
    input  logic                        i_key_val,
    input  logic                        i_key_loop,
    input  logic                        i_key_mode,
    input  logic                        i_dir,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic [NUM_FX-1:0]           i_fx_en,
    input  logic                        i_sample_valid,
    output logic [2:0]                  o_state,
    output logic [NUM_FX*PARAM_W-1:0]   o_params,
    output logic [NUM_FX-1:0]           o_fx_en,
    output logic [8:0]                  o_ledg,
    output logic [NUM_FX-1:0]           o_ledr,
    output logic [PARAM_W-1:0]          o_disp_val,
    output logic                        o_loop_wr,
    output logic                        o_loop_rd,
    output logic [LOOP_AW-1:0]          o_loop_addr,
    output logic [LOOP_AW:0]            o_loop_len
);

    localparam logic [PARAM_W-1:0] PMAX = {PARAM_W{1'b1}};

    state_t                      state;
    state_t                      state_nxt;
    logic [NUM_KEYS-1:0]         press;
    logic [NUM_FX*PARAM_W-1:0]   params_nxt;
    logic                        rec_empty;
    logic                        rec_done;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_val (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key_val),
        .o_press (press[KEY_VAL])
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key_mode),
        .o_press (press[KEY_MODE])
    );

`ifdef PEDAL_CTRL_LOOP_EN
    localparam logic [LOOP_AW:0] DEPTH = {1'b1, {LOOP_AW{1'b0}}};

    logic [LOOP_AW:0]   count;
    logic [LOOP_AW:0]   cnt_nxt;
    logic [LOOP_AW-1:0] addr;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_loop (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key_loop),
        .o_press (press[KEY_LOOP])
    );

    // count includes the sample being written this cycle
    assign cnt_nxt   = count + {{LOOP_AW{1'b0}}, i_sample_valid};
    assign rec_empty = (cnt_nxt == '0);
    assign rec_done  = (cnt_nxt == DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count      <= '0;
            addr       <= '0;
            o_loop_len <= '0;
        end else if (state == S_PLAY && state_nxt == S_RECD) begin
            count <= '0;
            addr  <= '0;
        end else if (state == S_RECD) begin
            if (state_nxt == S_PLAYL) begin
                o_loop_len <= cnt_nxt;
                count      <= '0;
                addr       <= '0;
            end else begin
                count <= cnt_nxt;
            end
        end else if (state == S_PLAYL && i_sample_valid) begin
            if ({1'b0, addr} == o_loop_len - 1'b1)
                addr <= '0;
            else
                addr <= addr + 1'b1;
        end
    end

    assign o_loop_wr   = (state == S_RECD) && i_sample_valid;
    assign o_loop_rd   = (state == S_PLAYL) && i_sample_valid;
    assign o_loop_addr = (state == S_RECD)  ? count[LOOP_AW-1:0] :
                         (state == S_PLAYL) ? addr : '0;
`else
    logic unused_loop;

    assign unused_loop     = i_key_loop ^ i_sample_valid;
    assign press[KEY_LOOP] = 1'b0;
    assign rec_empty       = 1'b1;
    assign rec_done        = 1'b0;
    assign o_loop_wr       = 1'b0;
    assign o_loop_rd       = 1'b0;
    assign o_loop_addr     = '0;
    assign o_loop_len      = '0;
`endif

    // mode is tested first so it wins over a coincident loop press
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_I2C:   if (i_i2c_done) state_nxt = S_PLAY;
            S_PLAY: begin
                if (press[KEY_MODE])      state_nxt = S_SET;
                else if (press[KEY_LOOP]) state_nxt = S_RECD;
            end
            S_SET:   if (press[KEY_MODE]) state_nxt = S_PLAY;
            S_RECD: begin
                if (press[KEY_LOOP])
                    state_nxt = rec_empty ? S_PLAY : S_PLAYL;
                else if (rec_done)
                    state_nxt = S_PLAYL;
            end
            S_PLAYL: if (press[KEY_LOOP]) state_nxt = S_PLAY;
            default: state_nxt = S_I2C;
        endcase
    end

    always_comb begin
        params_nxt = o_params;
        if (state == S_SET && press[KEY_VAL]) begin
            for (int i = 0; i < NUM_FX; i++) begin
                if (int'(i_sel) == i) begin
                    if (!i_dir && o_params[i*PARAM_W +: PARAM_W] != PMAX)
                        params_nxt[i*PARAM_W +: PARAM_W] =
                            o_params[i*PARAM_W +: PARAM_W] + 1'b1;
                    else if (i_dir && o_params[i*PARAM_W +: PARAM_W] != '0)
                        params_nxt[i*PARAM_W +: PARAM_W] =
                            o_params[i*PARAM_W +: PARAM_W] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_I2C;
            o_ledg   <= LEDG_I2C;
            o_fx_en  <= '0;
            o_params <= DEFAULTS;
        end else begin
            state    <= state_nxt;
            o_ledg   <= ledg_of(state_nxt);
            o_fx_en  <= (state_nxt == S_I2C) ? '0 : i_fx_en;
            o_params <= params_nxt;
        end
    end

    always_comb begin
        o_ledr     = i_fx_en;
        o_disp_val = '0;
        if (state == S_I2C) begin
            o_ledr = '0;
        end else if (state == S_SET) begin
            for (int i = 0; i < NUM_FX; i++) begin
                o_ledr[i] = (int'(i_sel) == i);
                if (int'(i_sel) == i)
                    o_disp_val = o_params[i*PARAM_W +: PARAM_W];
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pedal_ctrl.sv
// Self-checking bench for pedal_ctrl: vector table for parameter
// updates, hand sequences for debounce and loop record/playback.
module tb_pedal_ctrl;

    localparam int D  = 16;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i2c_done;
    logic        key_val;
    logic        key_loop;
    logic        key_mode;
    logic        dir;
    logic [2:0]  sel;
    logic [7:0]  fx_en;
    logic        sv;
    logic [2:0]  state;
    logic [23:0] params;
    logic [7:0]  fx_en_q;
    logic [8:0]  ledg;
    logic [7:0]  ledr;
    logic [2:0]  disp;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [3:0]  len;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       dir;
        logic [2:0] sel;
        logic [2:0] exp;
    } vec_t;

    vec_t     tbl [14];
    logic [2:0] sb_val [$];
    int         sb_addr [$];

    always #5 clk = ~clk;

    pedal_ctrl #(
        .NUM_FX       (8),
        .PARAM_W      (3),
        .DEFAULTS     (24'h000180),
        .DEBOUNCE_CYC (D),
        .LOOP_AW      (AW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_i2c_done     (i2c_done),
        .i_key_val      (key_val),
        .i_key_loop     (key_loop),
        .i_key_mode     (key_mode),
        .i_dir          (dir),
        .i_sel          (sel),
        .i_fx_en        (fx_en),
        .i_sample_valid (sv),
        .o_state        (state),
        .o_params       (params),
        .o_fx_en        (fx_en_q),
        .o_ledg         (ledg),
        .o_ledr         (ledr),
        .o_disp_val     (disp),
        .o_loop_wr      (wr),
        .o_loop_rd      (rd),
        .o_loop_addr    (addr),
        .o_loop_len     (len)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input bit v, input bit l, input bit m);
        key_val  = v;
        key_loop = l;
        key_mode = m;
        cycles(D + 4);
        key_val  = 1'b0;
        key_loop = 1'b0;
        key_mode = 1'b0;
        cycles(D + 4);
    endtask

    task automatic strobe(input bit is_rd, input int exp);
        int a;
        sv = 1'b1;
        sb_addr.push_back(exp);
        #1;
        a = sb_addr.pop_front();
        if (is_rd) check("rd_strobe", {31'd0, rd}, 32'd1);
        else       check("wr_strobe", {31'd0, wr}, 32'd1);
        check("loop_addr", {29'd0, addr}, a);
        @(posedge clk);
        #1 sv = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [2:0] slot(input logic [2:0] s);
        return 3'((params >> (s * 3)) & 24'h7);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 3'd2, 3'd7};
        tbl[1]  = '{1'b0, 3'd2, 3'd7};
        tbl[2]  = '{1'b0, 3'd2, 3'd7};
        tbl[3]  = '{1'b1, 3'd2, 3'd6};
        tbl[4]  = '{1'b1, 3'd2, 3'd5};
        tbl[5]  = '{1'b1, 3'd2, 3'd4};
        tbl[6]  = '{1'b1, 3'd2, 3'd3};
        tbl[7]  = '{1'b1, 3'd2, 3'd2};
        tbl[8]  = '{1'b1, 3'd2, 3'd1};
        tbl[9]  = '{1'b1, 3'd2, 3'd0};
        tbl[10] = '{1'b1, 3'd2, 3'd0};
        tbl[11] = '{1'b1, 3'd2, 3'd0};
        tbl[12] = '{1'b0, 3'd5, 3'd1};
        tbl[13] = '{1'b1, 3'd5, 3'd0};

        rst = 1'b1;
        i2c_done = 1'b0;
        key_val = 1'b0;
        key_loop = 1'b0;
        key_mode = 1'b0;
        dir = 1'b0;
        sel = 3'd2;
        fx_en = 8'h00;
        sv = 1'b0;
        cycles(3);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_ledg", {23'd0, ledg}, 32'h100);
        check("rst_params", {8'd0, params}, 32'h000180);
        check("rst_fx_en", {24'd0, fx_en_q}, 32'd0);
        check("rst_ledr", {24'd0, ledr}, 32'd0);
        check("rst_disp", {29'd0, disp}, 32'd0);
        check("rst_len", {28'd0, len}, 32'd0);
        check("rst_addr", {29'd0, addr}, 32'd0);

        rst = 1'b0;
        fx_en = 8'hA5;
        cycles(100);
        check("wait_state", {29'd0, state}, 32'd0);
        check("wait_ledg", {23'd0, ledg}, 32'h100);
        check("wait_fx_en", {24'd0, fx_en_q}, 32'd0);
        check("wait_ledr", {24'd0, ledr}, 32'd0);

        i2c_done = 1'b1;
        cycles(1);
        check("play_state", {29'd0, state}, 32'd1);
        check("play_ledg", {23'd0, ledg}, 32'h001);
        check("play_fx_en", {24'd0, fx_en_q}, 32'hA5);
        check("play_ledr", {24'd0, ledr}, 32'hA5);

        key_mode = 1'b1;
        cycles(10);
        key_mode = 1'b0;
        cycles(30);
        check("bounce_state", {29'd0, state}, 32'd1);

        key_mode = 1'b1;
        cycles(18);
        check("deb_c18", {29'd0, state}, 32'd1);
        cycles(1);
        check("deb_c19", {29'd0, state}, 32'd2);
        cycles(1);
        key_mode = 1'b0;
        cycles(30);
        check("deb_once", {29'd0, state}, 32'd2);
        check("set_ledg", {23'd0, ledg}, 32'h002);
        check("set_ledr", {24'd0, ledr}, 32'h04);
        check("set_disp", {29'd0, disp}, 32'd6);

        for (int i = 0; i < 14; i++) begin
            dir = tbl[i].dir;
            sel = tbl[i].sel;
            sb_val.push_back(tbl[i].exp);
            press(1'b1, 1'b0, 1'b0);
            begin
                logic [2:0] e;
                e = sb_val.pop_front();
                check($sformatf("slot_v%0d", i),
                      {29'd0, slot(sel)}, {29'd0, e});
                check($sformatf("disp_v%0d", i),
                      {29'd0, disp}, {29'd0, e});
            end
        end

        press(1'b0, 1'b1, 1'b0);
        check("set_loop_ign", {29'd0, state}, 32'd2);
        press(1'b0, 1'b0, 1'b1);
        check("set_to_play", {29'd0, state}, 32'd1);
        dir = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check("val_outside", {29'd0, slot(3'd5)}, 32'd0);
        check("disp_play", {29'd0, disp}, 32'd0);

        press(1'b0, 1'b1, 1'b1);
        check("simul_keys", {29'd0, state}, 32'd2);
        press(1'b0, 1'b0, 1'b1);
        check("back_play", {29'd0, state}, 32'd1);

`ifdef PEDAL_CTRL_LOOP_EN
        press(1'b0, 1'b1, 1'b0);
        check("recd_state", {29'd0, state}, 32'd3);
        check("recd_ledg", {23'd0, ledg}, 32'h004);
        for (int i = 0; i < 5; i++) strobe(1'b0, i);
        press(1'b0, 1'b1, 1'b0);
        check("playl_state", {29'd0, state}, 32'd4);
        check("playl_len", {28'd0, len}, 32'd5);
        for (int i = 0; i < 7; i++) strobe(1'b1, i % 5);
        press(1'b0, 1'b1, 1'b0);
        check("playl_exit", {29'd0, state}, 32'd1);

        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("empty_loop", {29'd0, state}, 32'd1);

        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) strobe(1'b0, i);
        check("auto_state", {29'd0, state}, 32'd4);
        check("auto_len", {28'd0, len}, 32'd8);

        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        strobe(1'b0, 0);
        strobe(1'b0, 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rstrec_state", {29'd0, state}, 32'd0);
        check("rstrec_len", {28'd0, len}, 32'd0);
        check("rstrec_ledg", {23'd0, ledg}, 32'h100);
`else
        press(1'b0, 1'b1, 1'b0);
        check("noloop_state", {29'd0, state}, 32'd1);
        sv = 1'b1;
        #1;
        check("noloop_wr", {31'd0, wr}, 32'd0);
        check("noloop_rd", {31'd0, rd}, 32'd0);
        check("noloop_addr", {29'd0, addr}, 32'd0);
        check("noloop_len", {28'd0, len}, 32'd0);
        sv = 1'b0;
        cycles(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
